// File: rtl/ipml_prefetch_sfifo_pkg.sv
// Shared helpers for the up-sizing prefetch FIFO: width math, lane placement, credit width.
package ipml_prefetch_sfifo_pkg;

  localparam int CREDIT_W = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int RD_WIDTH_OF(input int w, input int r);
    return w * r;
  endfunction

  // Slot index inside the wide word for beat number 'lane'.
  function automatic int lane_slot(input int lane, input int ratio, input bit little);
    return little ? lane : (ratio - 1 - lane);
  endfunction

endpackage

// File: rtl/ipml_reg_fifo_sync2.sv
// Two-entry register FIFO, head presented straight from a register; one-edge fill latency.
// No input ready: the producer must never push more than the free space (credit-limited upstream).
module ipml_reg_fifo_sync2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_dat,
  input  logic         in_vld,
  output logic [W-1:0] out_dat,
  output logic         out_vld,
  input  logic         out_rdy
);

  logic [W-1:0] q1;
  logic [1:0]   cnt;
  logic         pop;

  assign out_vld = (cnt != 2'd0);
  assign pop     = out_vld & out_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 2'd0;
      out_dat <= '0;
      q1      <= '0;
    end else begin
      case ({in_vld, pop})
        2'b10: begin
          if (cnt == 2'd0) out_dat <= in_dat;
          else             q1      <= in_dat;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          if (cnt == 2'd2) out_dat <= q1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) out_dat <= in_dat;
          else begin
            out_dat <= q1;
            q1      <= in_dat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ipml_prefetch_sfifo_upsz.sv
// Single-clock FWFT FIFO packing narrow beats into wide words; commit-to-rd_vld is 3 edges.
// wr_vld drops only when the RAM is full; reads are credit-limited so the output buffer never overflows.
module ipml_prefetch_sfifo_upsz
  import ipml_prefetch_sfifo_pkg::*;
#(
  parameter int c_WR_DATA_WIDTH    = 8,
  parameter int c_RATIO            = 4,
  parameter int c_DEPTH_WIDTH      = 6,
  parameter int c_ALMOST_FULL_NUM  = 60,
  parameter int c_ALMOST_EMPTY_NUM = 2,
  parameter int c_LITTLE_ENDIAN    = 1,
  localparam int c_RD_DATA_WIDTH   = RD_WIDTH_OF(c_WR_DATA_WIDTH, c_RATIO)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [c_WR_DATA_WIDTH-1:0] wr_data,
  input  logic                       wr_en,
  input  logic                       wr_last,
  output logic                       wr_vld,
  output logic [c_RD_DATA_WIDTH-1:0] rd_data,
  output logic [c_RATIO-1:0]         rd_keep,
  output logic                       rd_vld,
  input  logic                       rd_en,
  output logic [c_DEPTH_WIDTH:0]     wr_water_level,
  output logic                       almost_full,
  output logic                       almost_empty
);

  localparam int LANE_W = (c_RATIO > 1) ? clog2(c_RATIO) : 1;
  localparam int WORD_W = c_RD_DATA_WIDTH + c_RATIO;
  localparam int DEPTH  = 1 << c_DEPTH_WIDTH;
  localparam int PW     = c_DEPTH_WIDTH + 1;
  localparam logic [PW-1:0] AF_LVL = PW'(c_ALMOST_FULL_NUM);
  localparam logic [PW-1:0] AE_LVL = PW'(c_ALMOST_EMPTY_NUM);

  logic [LANE_W-1:0]          lane_q;
  logic [c_RD_DATA_WIDTH-1:0] gat_q, word_nxt;
  logic [c_RATIO-1:0]         keep_q, keep_nxt;
  logic [PW-1:0]              wptr, rptr;
  logic [CREDIT_W-1:0]        credit_q;
  logic [WORD_W-1:0]          mem [0:DEPTH-1];
  logic [WORD_W-1:0]          ram_q, buf_dat;
  logic                       ram_vld;
  logic                       full, empty, wr_acc, commit, pop, rd_issue;

  assign full   = (wptr[c_DEPTH_WIDTH] != rptr[c_DEPTH_WIDTH]) &&
                  (wptr[c_DEPTH_WIDTH-1:0] == rptr[c_DEPTH_WIDTH-1:0]);
  assign empty  = (wptr == rptr);
  assign wr_vld = ~rst & ~full;
  assign wr_acc = wr_en & wr_vld;
  assign commit = wr_acc & (wr_last | (lane_q == LANE_W'(c_RATIO - 1)));

  assign pop      = rd_vld & rd_en;
  assign rd_issue = ~empty & ((credit_q < CREDIT_W'(2)) | pop);

  assign wr_water_level = wptr - rptr;
  assign almost_full    = (wr_water_level >= AF_LVL);
  assign almost_empty   = (wr_water_level <= AE_LVL);

  // Incoming beat merged into the gather word; this is what a commit writes.
  always_comb begin
    word_nxt = gat_q;
    keep_nxt = keep_q;
    for (int k = 0; k < c_RATIO; k++) begin
      if (lane_q == LANE_W'(k)) begin
        word_nxt[lane_slot(k, c_RATIO, c_LITTLE_ENDIAN != 0)*c_WR_DATA_WIDTH +: c_WR_DATA_WIDTH] = wr_data;
        keep_nxt[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= '0;
      gat_q  <= '0;
      keep_q <= '0;
    end else if (wr_acc) begin
      if (commit) begin
        lane_q <= '0;
        gat_q  <= '0;
        keep_q <= '0;
      end else begin
        lane_q <= lane_q + LANE_W'(1);
        gat_q  <= word_nxt;
        keep_q <= keep_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit) mem[wptr[c_DEPTH_WIDTH-1:0]] <= {word_nxt, keep_nxt};
    if (rd_issue) ram_q <= mem[rptr[c_DEPTH_WIDTH-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      credit_q <= '0;
      ram_vld  <= 1'b0;
    end else begin
      if (commit)   wptr <= wptr + PW'(1);
      if (rd_issue) rptr <= rptr + PW'(1);
      ram_vld <= rd_issue;
      case ({rd_issue, pop})
        2'b10:   credit_q <= credit_q + CREDIT_W'(1);
        2'b01:   credit_q <= credit_q - CREDIT_W'(1);
        default: ;
      endcase
    end
  end

  ipml_reg_fifo_sync2 #(.W(WORD_W)) u_obuf (
    .clk     (clk),
    .rst     (rst),
    .in_dat  (ram_q),
    .in_vld  (ram_vld),
    .out_dat (buf_dat),
    .out_vld (rd_vld),
    .out_rdy (rd_en)
  );

  assign {rd_data, rd_keep} = buf_dat;

endmodule
